// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row/column position to key code: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    unique case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and entry-side signals of the scanner; slave = scanner, master = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] ones;
  logic [3:0] tens;

  modport master (
    output row_n,
    input  col_n, key_code, key_valid, key_held, ones, tens
  );

  modport slave (
    input  row_n,
    output col_n, key_code, key_valid, key_held, ones, tens
  );
endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running divider: tick is high for one cycle every TICKS+1 clocks.
module keypad_tick_gen #(
  parameter int unsigned TICKS = 49_999
) (
  input  logic clk_50MHz,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned W = $clog2(TICKS + 2);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_q == W'(TICKS)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == W'(TICKS));

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a 2-digit BCD entry register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS  = 49_999,
  parameter int unsigned DEBOUNCE_MS = 20
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
`endif
) (
  input  logic          clk_50MHz,
  input  logic          reset_n,
  keypad_scan_if.slave  kp
);

  localparam int unsigned DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned DEB_LAST = (DEBOUNCE_MS >= 2) ? DEBOUNCE_MS - 2 : 0;
  localparam int unsigned REL_LAST = (DEBOUNCE_MS >= 1) ? DEBOUNCE_MS - 1 : 0;

  logic          tick;
  logic [3:0]    rs1_q, rs_q;
  state_e        state_q;
  logic [3:0]    col_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    row_q;
  logic [DW-1:0] deb_q, rel_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;
  logic [3:0]    ones_q, tens_q;

  logic          one_low;
  logic [1:0]    low_idx;
  logic [3:0]    key_code_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_q;
  logic          first_q;
`endif

  keypad_tick_gen #(.TICKS(SCAN_TICKS)) u_tick (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .tick      (tick)
  );

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q <= '1;
      rs_q  <= '1;
    end else begin
      rs1_q <= kp.row_n;
      rs_q  <= rs1_q;
    end
  end

  always_comb begin
    one_low = $onehot(~rs_q);
    low_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rs_q[i]) low_idx = 2'(i);
    end
    key_code_d = keymap((state_q == SCAN) ? low_idx : row_q, col_idx_q);
  end

  // A single-tick debounce accepts directly from SCAN; otherwise the detect tick counts as the first stable one.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      col_q       <= 4'b1110;
      col_idx_q   <= '0;
      row_q       <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      first_q     <= 1'b1;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (one_low) begin
              row_q <= low_idx;
              deb_q <= '0;
              if (DEBOUNCE_MS <= 1) begin
                key_code_q  <= key_code_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= '0;
                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= '0;
                first_q     <= 1'b1;
`endif
              end else begin
                state_q <= DEBOUNCE;
              end
            end else begin
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (rs_q == ~(4'b0001 << row_q)) begin
              if (deb_q == DW'(DEB_LAST)) begin
                key_code_q  <= key_code_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_q       <= '0;
                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= '0;
                first_q     <= 1'b1;
`endif
              end else begin
                deb_q <= deb_q + DW'(1);
              end
            end else begin
              state_q   <= SCAN;
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          HELD: begin
            if (!rs_q[row_q]) begin
              rel_q <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (first_q ? (rpt_q == RW'(REPEAT_DELAY - 1)) : (rpt_q == RW'(REPEAT_RATE - 1))) begin
                key_valid_q <= 1'b1;
                rpt_q       <= '0;
                first_q     <= 1'b0;
              end else begin
                rpt_q <= rpt_q + RW'(1);
              end
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rpt_q <= '0;
`endif
              if (rel_q == DW'(REL_LAST)) begin
                key_held_q <= 1'b0;
                state_q    <= SCAN;
                col_q      <= {col_q[2:0], col_q[3]};
                col_idx_q  <= col_idx_q + 2'd1;
              end else begin
                rel_q <= rel_q + DW'(1);
              end
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      ones_q <= '0;
      tens_q <= '0;
    end else if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        tens_q <= ones_q;
        ones_q <= key_code_q;
      end else if (key_code_q == KEY_STAR) begin
        ones_q <= '0;
        tens_q <= '0;
      end
    end
  end

  assign kp.col_n     = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.ones      = ones_q;
  assign kp.tens      = tens_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a combinational matrix model (SCAN_TICKS=9, DEBOUNCE_MS=3).
module tb_keypad_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  bit         k_en  [2];
  logic [1:0] k_row [2];
  logic [1:0] k_col [2];

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_TICKS  (9),
    .DEBOUNCE_MS (3)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
`endif
  ) dut (
    .clk_50MHz (clk),
    .reset_n   (rst_n),
    .kp        (kp)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    kp.row_n = 4'hF;
    for (int i = 0; i < 2; i++) begin
      if (k_en[i] && !kp.col_n[k_col[i]]) kp.row_n[k_row[i]] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int slot, input logic [1:0] r, input logic [1:0] c);
    k_row[slot] = r;
    k_col[slot] = c;
    k_en[slot]  = 1'b1;
  endtask

  task automatic clr_keys();
    k_en[0] = 1'b0;
    k_en[1] = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 80) begin
      @(negedge clk);
      n++;
      if (kp.key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (kp.key_held === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic tap(input logic [1:0] r, input logic [1:0] c, input string tag);
    logic ok;
    set_key(0, r, c);
    wait_valid(ok);
    check({tag, "_strobe"}, 32'(ok), 1);
    repeat (40) @(negedge clk);
    clr_keys();
    wait_release(50, ok);
    check({tag, "_release"}, 32'(ok), 1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic       ok;
    int         v0;
    int         changes;
    logic [3:0] prev_col;

    clr_keys();
    k_row[0] = '0; k_col[0] = '0; k_row[1] = '0; k_col[1] = '0;

    repeat (3) @(negedge clk);
    check("rst_col_n", 32'(kp.col_n), 32'h0E);
    check("rst_key_code", 32'(kp.key_code), 0);
    check("rst_key_valid", 32'(kp.key_valid), 0);
    check("rst_key_held", 32'(kp.key_held), 0);
    check("rst_ones", 32'(kp.ones), 0);
    check("rst_tens", 32'(kp.tens), 0);
    rst_n = 1'b1;

    // 1: idle column rotation, one step every 10 clocks
    begin
      int n = 0;
      while (kp.col_n === 4'b1110 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("rot_1", 32'(kp.col_n), 32'h0D);
    repeat (10) @(negedge clk);
    check("rot_2", 32'(kp.col_n), 32'h0B);
    repeat (10) @(negedge clk);
    check("rot_3", 32'(kp.col_n), 32'h07);
    repeat (10) @(negedge clk);
    check("rot_4", 32'(kp.col_n), 32'h0E);
    check("idle_no_strobe", 32'(valid_cnt), 0);

    // 2: press '5', hold, release
    v0 = valid_cnt;
    set_key(0, 2'd1, 2'd1);
    wait_valid(ok);
    check("k5_strobe", 32'(ok), 1);
    check("k5_code", 32'(kp.key_code), 5);
    check("k5_held", 32'(kp.key_held), 1);
    repeat (60) @(negedge clk);
    check("k5_count", 32'(valid_cnt - v0), 1);
    check("k5_ones", 32'(kp.ones), 5);
    check("k5_tens", 32'(kp.tens), 0);
    clr_keys();
    repeat (19) @(negedge clk);
    check("k5_held_after_release", 32'(kp.key_held), 1);
    wait_release(15, ok);
    check("k5_release", 32'(ok), 1);
    repeat (20) @(negedge clk);
    check("k5_single", 32'(valid_cnt - v0), 1);

    // 3: digit entry shifting and clear
    tap(2'd2, 2'd0, "k7");
    tap(2'd0, 2'd1, "k2");
    check("e72_tens", 32'(kp.tens), 7);
    check("e72_ones", 32'(kp.ones), 2);
    tap(2'd2, 2'd2, "k9");
    check("e29_tens", 32'(kp.tens), 2);
    check("e29_ones", 32'(kp.ones), 9);
    tap(2'd3, 2'd0, "kstar");
    check("star_code", 32'(kp.key_code), 32'hE);
    check("star_ones", 32'(kp.ones), 0);
    check("star_tens", 32'(kp.tens), 0);

    // 4: bouncing '3' then stable
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      set_key(0, 2'd0, 2'd2);
      repeat (10) @(negedge clk);
      clr_keys();
      repeat (10) @(negedge clk);
    end
    check("bounce_no_strobe", 32'(valid_cnt - v0), 0);
    set_key(0, 2'd0, 2'd2);
    wait_valid(ok);
    check("k3_strobe", 32'(ok), 1);
    check("k3_code", 32'(kp.key_code), 3);
    repeat (30) @(negedge clk);
    check("k3_count", 32'(valid_cnt - v0), 1);
    clr_keys();
    wait_release(50, ok);
    check("k3_release", 32'(ok), 1);
    repeat (20) @(negedge clk);

    // 5: ghosting on column 0, then reset in the middle of a debounce
    v0 = valid_cnt;
    set_key(0, 2'd0, 2'd0);
    set_key(1, 2'd2, 2'd0);
    changes = 0;
    prev_col = kp.col_n;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (kp.col_n !== prev_col) changes++;
      prev_col = kp.col_n;
    end
    check("ghost_rotations", 32'(changes), 6);
    check("ghost_no_strobe", 32'(valid_cnt - v0), 0);
    clr_keys();
    set_key(0, 2'd1, 2'd1);
    begin
      int n = 0;
      while (kp.col_n !== 4'b1101 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (15) @(negedge clk);
    check("mid_deb_col", 32'(kp.col_n), 32'h0D);
    check("mid_deb_no_strobe", 32'(valid_cnt - v0), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_col_n", 32'(kp.col_n), 32'h0E);
    check("async_rst_key_code", 32'(kp.key_code), 0);
    check("async_rst_key_held", 32'(kp.key_held), 0);
    check("async_rst_ones", 32'(kp.ones), 0);
    check("async_rst_tens", 32'(kp.tens), 0);
    clr_keys();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 6: long hold of '1'
    v0 = valid_cnt;
    set_key(0, 2'd0, 2'd0);
    wait_valid(ok);
    check("k1_strobe", 32'(ok), 1);
    repeat (115) @(negedge clk);
    clr_keys();
    wait_release(50, ok);
    check("k1_release", 32'(ok), 1);
    repeat (5) @(negedge clk);
    check("k1_code", 32'(kp.key_code), 1);
`ifdef KEYPAD_REPEAT_EN
    check("k1_strobes", 32'(valid_cnt - v0), 5);
    check("k1_tens", 32'(kp.tens), 1);
`else
    check("k1_strobes", 32'(valid_cnt - v0), 1);
    check("k1_tens", 32'(kp.tens), 0);
`endif
    check("k1_ones", 32'(kp.ones), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
